pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard control for a classic 5-stage MIPS-style pipeline. It detects
//   load-use hazards and stalls, flushes the front end on a taken branch
//   resolved in MEM, and selects ALU operand forwarding.
//
//   Build option HAZARD_FORWARD_EN:
//     defined   - EX/MEM and MEM/WB forwarding is enabled; only a load-use
//                 dependency stalls.
//     undefined - forwarding outputs are tied to 00. Any RAW dependency of the
//                 IF/ID instruction on an in-flight write (ID/EX, EX/MEM,
//                 MEM/WB) stalls until every one has drained.
//
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     if_id_instr         instruction in IF/ID (rs/rt decoded here)
//     id_ex_*             ID/EX sources, destination, mem_read, reg_write
//     ex_mem_*, mem_wb_*  later-stage destinations and write enables
//     ex_mem_pcsrc        branch taken, resolved in MEM
//     pc_write, if_id_write, id_ex_bubble   stall controls
//     if_id_flush, id_ex_flush, ex_mem_flush branch flush controls
//     forward_a, forward_b  00 regfile, 01 MEM/WB, 10 EX/MEM
//     ctrl_state          00 RUN, 01 STALL, 10 FLUSH
//     stall_cnt, flush_cnt  saturating event counters
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_instr,
  input  logic [4:0]  id_ex_rs,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  id_ex_dest,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  ex_mem_dest,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  mem_wb_dest,
  input  logic        mem_wb_reg_write,
  input  logic        ex_mem_pcsrc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StStall = 2'b01,
    StFlush = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // IF/ID decode: rt is only a source for R-type, beq and sw.
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       rt_src;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rt_src = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h2B);

  // A zero destination never creates a dependency.
  logic dep_id_ex;
  assign dep_id_ex = (id_ex_dest != 5'd0) &&
                     ((id_ex_dest == rs) || (rt_src && (id_ex_dest == rt)));

  logic hazard;

`ifdef HAZARD_FORWARD_EN
  assign hazard = id_ex_mem_read && dep_id_ex;

  always_comb begin
    forward_a = 2'b00;
    if (reset) begin
      if (ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs)) begin
        forward_a = 2'b10;
      end else if (mem_wb_reg_write && (mem_wb_dest != 5'd0) && (mem_wb_dest == id_ex_rs)) begin
        forward_a = 2'b01;
      end
    end
  end

  always_comb begin
    forward_b = 2'b00;
    if (reset) begin
      if (ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt)) begin
        forward_b = 2'b10;
      end else if (mem_wb_reg_write && (mem_wb_dest != 5'd0) && (mem_wb_dest == id_ex_rt)) begin
        forward_b = 2'b01;
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{if_id_instr[15:0], id_ex_reg_write};
`else
  logic dep_ex_mem, dep_mem_wb;
  assign dep_ex_mem = (ex_mem_dest != 5'd0) &&
                      ((ex_mem_dest == rs) || (rt_src && (ex_mem_dest == rt)));
  assign dep_mem_wb = (mem_wb_dest != 5'd0) &&
                      ((mem_wb_dest == rs) || (rt_src && (mem_wb_dest == rt)));

  // Without forwarding every in-flight write to a source must retire first.
  assign hazard = ((id_ex_mem_read || id_ex_reg_write) && dep_id_ex) ||
                  (ex_mem_reg_write && dep_ex_mem) ||
                  (mem_wb_reg_write && dep_mem_wb);

  assign forward_a = 2'b00;
  assign forward_b = 2'b00;

  logic unused_sig;
  assign unused_sig = ^{if_id_instr[15:0], id_ex_rs, id_ex_rt};
`endif

  // Next state and stall/flush controls. The reset gate keeps the pipeline
  // free-running while reset is held, whatever the inputs show.
  always_comb begin
    state_d      = StRun;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (reset) begin
      if (ex_mem_pcsrc) begin
        // Taken branch wins over any stall.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = StFlush;
      end else begin
        case (state_q)
          StFlush: state_d = StRun;  // hazard masked for one cycle
          default: begin             // StRun, StStall and unreachable 2'b11
            if (hazard) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
              state_d      = StStall;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (id_ex_bubble && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (ex_mem_pcsrc && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; works with or without
// HAZARD_FORWARD_EN defined.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] if_id_instr;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic        id_ex_mem_read, id_ex_reg_write;
  logic [4:0]  ex_mem_dest;
  logic        ex_mem_reg_write;
  logic [4:0]  mem_wb_dest;
  logic        mem_wb_reg_write;
  logic        ex_mem_pcsrc;
  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  forward_a, forward_b, ctrl_state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_instr      (if_id_instr),
    .id_ex_rs         (id_ex_rs),
    .id_ex_rt         (id_ex_rt),
    .id_ex_dest       (id_ex_dest),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_reg_write  (id_ex_reg_write),
    .ex_mem_dest      (ex_mem_dest),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_dest      (mem_wb_dest),
    .mem_wb_reg_write (mem_wb_reg_write),
    .ex_mem_pcsrc     (ex_mem_pcsrc),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .id_ex_bubble     (id_ex_bubble),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .forward_a        (forward_a),
    .forward_b        (forward_b),
    .ctrl_state       (ctrl_state),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks pc_write, if_id_write, bubble and all three flushes.
  task automatic ctl(input string tag, input logic pcw, input logic bub, input logic fl);
    chk1({tag, ".pc_write"}, pc_write, pcw);
    chk1({tag, ".if_id_write"}, if_id_write, pcw);
    chk1({tag, ".bubble"}, id_ex_bubble, bub);
    chk1({tag, ".if_id_flush"}, if_id_flush, fl);
    chk1({tag, ".id_ex_flush"}, id_ex_flush, fl);
    chk1({tag, ".ex_mem_flush"}, ex_mem_flush, fl);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
    return {op, s, t, 16'h0020};
  endfunction

  task automatic clr;
    if_id_instr = 32'd0;
    id_ex_rs = 5'd0; id_ex_rt = 5'd0; id_ex_dest = 5'd0;
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0;
    ex_mem_dest = 5'd0; ex_mem_reg_write = 1'b0;
    mem_wb_dest = 5'd0; mem_wb_reg_write = 1'b0;
    ex_mem_pcsrc = 1'b0;
  endtask

  // lw $2 in ID/EX, add $3,$2,$4 in IF/ID
  task automatic load_use;
    if_id_instr = mk(6'h00, 5'd2, 5'd4);
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_dest = 5'd2;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    // Reset held with hostile inputs: outputs must stay at defaults.
    load_use();
    ex_mem_pcsrc = 1'b1;
    id_ex_rs = 5'd5; ex_mem_dest = 5'd5; ex_mem_reg_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk2("rst.state", ctrl_state, 2'b00);
    chk16("rst.stall_cnt", stall_cnt, 16'd0);
    chk16("rst.flush_cnt", flush_cnt, 16'd0);
    ctl("rst", 1'b1, 1'b0, 1'b0);
    chk2("rst.fwd_a", forward_a, 2'b00);
    clr();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single load-use stall
    load_use();
    #1;
    ctl("lu", 1'b0, 1'b1, 1'b0);
    chk2("lu.state0", ctrl_state, 2'b00);
    tick();
    chk2("lu.state1", ctrl_state, 2'b01);
    chk16("lu.stall_cnt", stall_cnt, 16'd1);
    clr();
    #1;
    ctl("lu.release", 1'b1, 1'b0, 1'b0);
    tick();
    chk2("lu.state2", ctrl_state, 2'b00);
    chk16("lu.stall_cnt2", stall_cnt, 16'd1);

    // rt-as-source decode and register-0 rule, combinational in RUN
    id_ex_mem_read = 1'b1; id_ex_dest = 5'd7;
    if_id_instr = mk(6'h2B, 5'd0, 5'd7);
    #1 chk1("sw_rt.bubble", id_ex_bubble, 1'b1);
    if_id_instr = mk(6'h08, 5'd0, 5'd7);
    #1 chk1("addi_rt.bubble", id_ex_bubble, 1'b0);
    if_id_instr = mk(6'h04, 5'd0, 5'd7);
    #1 chk1("beq_rt.bubble", id_ex_bubble, 1'b1);
    if_id_instr = mk(6'h08, 5'd7, 5'd0);
    #1 chk1("addi_rs.bubble", id_ex_bubble, 1'b1);
    id_ex_dest = 5'd0;
    if_id_instr = mk(6'h00, 5'd0, 5'd0);
    #1 chk1("reg0.bubble", id_ex_bubble, 1'b0);
    id_ex_mem_read = 1'b0; id_ex_dest = 5'd7;
    if_id_instr = mk(6'h00, 5'd7, 5'd1);
    #1 chk1("noload.bubble", id_ex_bubble, 1'b0);
    clr();

    // Branch coincident with load-use
    load_use();
    ex_mem_pcsrc = 1'b1;
    #1;
    ctl("br", 1'b1, 1'b0, 1'b1);
    tick();
    chk2("br.state", ctrl_state, 2'b10);
    chk16("br.flush_cnt", flush_cnt, 16'd1);
    chk16("br.stall_cnt", stall_cnt, 16'd1);
    ex_mem_pcsrc = 1'b0;
    #1;
    ctl("flush.mask", 1'b1, 1'b0, 1'b0);
    tick();
    chk2("flush.exit", ctrl_state, 2'b00);
    chk16("flush.stall_cnt", stall_cnt, 16'd1);
    chk1("run.hazard", id_ex_bubble, 1'b1);
    ex_mem_pcsrc = 1'b1;
    tick();
    tick();
    chk2("br2.state", ctrl_state, 2'b10);
    chk16("br2.flush_cnt", flush_cnt, 16'd3);
    clr();
    tick();
    chk2("br2.exit", ctrl_state, 2'b00);
    // Branch arriving during STALL
    load_use();
    tick();
    chk2("sb.stall", ctrl_state, 2'b01);
    ex_mem_pcsrc = 1'b1;
    #1;
    ctl("sb", 1'b1, 1'b0, 1'b1);
    tick();
    chk2("sb.state", ctrl_state, 2'b10);
    chk16("sb.stall_cnt", stall_cnt, 16'd2);
    chk16("sb.flush_cnt", flush_cnt, 16'd4);
    clr();
    tick();

`ifdef HAZARD_FORWARD_EN
    id_ex_rs = 5'd5; ex_mem_dest = 5'd5; mem_wb_dest = 5'd5;
    ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
    #1 chk2("fwd_a.exmem", forward_a, 2'b10);
    ex_mem_reg_write = 1'b0;
    #1 chk2("fwd_a.memwb", forward_a, 2'b01);
    mem_wb_dest = 5'd0;
    #1 chk2("fwd_a.zero", forward_a, 2'b00);
    clr();
    id_ex_rt = 5'd6; ex_mem_dest = 5'd6; mem_wb_dest = 5'd6;
    ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
    #1 chk2("fwd_b.exmem", forward_b, 2'b10);
    chk2("fwd_b.a_idle", forward_a, 2'b00);
    ex_mem_dest = 5'd9;
    #1 chk2("fwd_b.memwb", forward_b, 2'b01);
    clr();
    // ALU producer is forwarded, no stall
    if_id_instr = mk(6'h00, 5'd2, 5'd3);
    ex_mem_dest = 5'd2; ex_mem_reg_write = 1'b1;
    id_ex_dest = 5'd2; id_ex_reg_write = 1'b1;
    #1 ctl("fwd.nostall", 1'b1, 1'b0, 1'b0);
    clr();
`else
    id_ex_rs = 5'd5; ex_mem_dest = 5'd5; mem_wb_dest = 5'd5;
    ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
    #1 chk2("nofwd.fwd_a", forward_a, 2'b00);
    clr();
    // add $2 in EX/MEM, sub using $2: stall through EX/MEM and MEM/WB
    if_id_instr = mk(6'h00, 5'd2, 5'd3);
    ex_mem_dest = 5'd2; ex_mem_reg_write = 1'b1;
    #1 ctl("raw.exmem", 1'b0, 1'b1, 1'b0);
    tick();
    chk2("raw.state1", ctrl_state, 2'b01);
    ex_mem_dest = 5'd0; ex_mem_reg_write = 1'b0;
    mem_wb_dest = 5'd2; mem_wb_reg_write = 1'b1;
    #1 ctl("raw.memwb", 1'b0, 1'b1, 1'b0);
    tick();
    chk2("raw.state2", ctrl_state, 2'b01);
    chk16("raw.stall_cnt", stall_cnt, 16'd4);
    clr();
    #1 ctl("raw.clear", 1'b1, 1'b0, 1'b0);
    tick();
    chk2("raw.run", ctrl_state, 2'b00);
    if_id_instr = mk(6'h00, 5'd0, 5'd2);
    id_ex_dest = 5'd2; id_ex_reg_write = 1'b1;
    #1 chk1("raw.idex", id_ex_bubble, 1'b1);
    clr();
`endif

    // Reset mid-STALL
    load_use();
    tick();
    chk2("ms.stall", ctrl_state, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk2("ms.state", ctrl_state, 2'b00);
    chk16("ms.stall_cnt", stall_cnt, 16'd0);
    chk16("ms.flush_cnt", flush_cnt, 16'd0);
    ctl("ms", 1'b1, 1'b0, 1'b0);
    clr();
    @(negedge clk);
    reset = 1'b1;
    // Reset mid-FLUSH, then a hazard must not be masked after release
    ex_mem_pcsrc = 1'b1;
    tick();
    chk2("mf.flush", ctrl_state, 2'b10);
    #2 reset = 1'b0;
    #1 chk2("mf.state", ctrl_state, 2'b00);
    clr();
    load_use();
    @(negedge clk);
    reset = 1'b1;
    #1 chk1("mf.bubble", id_ex_bubble, 1'b1);
    tick();
    chk2("mf.stall", ctrl_state, 2'b01);
    chk16("mf.stall_cnt", stall_cnt, 16'd1);

    // Saturation: hazard held, counter already at 1
    repeat (65533) tick();
    chk16("sat.fffe", stall_cnt, 16'hFFFE);
    tick();
    chk16("sat.ffff", stall_cnt, 16'hFFFF);
    tick();
    chk16("sat.hold", stall_cnt, 16'hFFFF);
    chk2("sat.state", ctrl_state, 2'b01);
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
